// File: rtl/nsac_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package nsac_pkg;
  localparam int NIBBLE_W    = 4;
  localparam int NIBBLES_MIN = 2;
  localparam int NIBBLES_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result bundle for nibble_serial_add_ctrl.
// The master drives the requests and the slave returns the results.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  import nsac_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, abort, a, b, cin, sub,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, abort, a, b, cin, sub,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/nsac_slice4.sv
// Combinational 4-bit ripple-carry adder slice, reused once per RUN cycle.
module nsac_slice4
  import nsac_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  logic c;

  // Ripple the carry through the four bit positions.
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial W-bit adder: one 4-bit slice processes one nibble per RUN
// cycle, from nibble 0 upward, carrying through a one-bit carry register.
// Optional feature macro: NSAC_SUB_EN (enables a-b via the sub request).
module nibble_serial_add_ctrl
  import nsac_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (NIBBLES < NIBBLES_MIN || NIBBLES > NIBBLES_MAX) begin : g_bad_nibbles
    $error("NIBBLES out of legal range");
  end

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [W-1:0]         a_q, b_q, sum_q;
  logic                 carry_q, cout_q, ovf_q;
  logic                 accept, last;
  logic [W-1:0]         b_in;
  logic                 ci_in;
  logic [W-1:0]         a_sh, b_sh;
  logic [NIBBLE_W-1:0]  a_nib, b_nib, s_nib;
  logic                 co_nib, c_msb;

`ifdef NSAC_SUB_EN
  // Subtraction is a + ~b + 1; the inversion is folded into the operand latch.
  assign b_in  = bus.sub ? ~bus.b : bus.b;
  assign ci_in = bus.sub ? 1'b1 : bus.cin;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_in  = bus.b;
  assign ci_in = bus.cin;
`endif

  assign accept = (state_q != RUN) && bus.start && !bus.abort;
  assign last   = (idx_q == LAST_IDX);

  assign a_sh  = a_q >> (NIBBLE_W * idx_q);
  assign b_sh  = b_q >> (NIBBLE_W * idx_q);
  assign a_nib = a_sh[NIBBLE_W-1:0];
  assign b_nib = b_sh[NIBBLE_W-1:0];

  nsac_slice4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co_nib)
  );

  // Carry into the slice MSB, recovered from its sum bit; used for overflow.
  assign c_msb = a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ s_nib[NIBBLE_W-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort always beats start, and DONE may chain into RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (bus.abort) state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
  end

  // Operand latch, nibble index, carry chain and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= b_in;
      carry_q <= ci_in;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == RUN) begin
      if (bus.abort) begin
        idx_q   <= '0;
        carry_q <= 1'b0;
        sum_q   <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) sum_q[NIBBLE_W*i +: NIBBLE_W] <= s_nib;
        end
        carry_q <= co_nib;
        idx_q   <= idx_q + IDX_W'(1);
        if (last) begin
          cout_q <= co_nib;
          ovf_q  <= c_msb ^ co_nib;
        end
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl with NIBBLES=4.
module tb_nibble_serial_add_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  nibble_serial_add_ctrl_if #(.NIBBLES(4)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, output int nbusy, output logic seen_done,
                        output logic ovf_acc);
    bus.a = av;
    bus.b = bv;
    bus.cin = ci;
    bus.sub = sb;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ovf_acc = bus.ovf;
    nbusy = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (bus.busy) nbusy++;
      if (bus.done) seen_done = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int   nb;
    logic sd;
    logic oa;
    int   ndone;

    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;

    #3;
    check("rst_sum",  32'(bus.sum),  32'h0);
    check("rst_cout", 32'(bus.cout), 32'h0);
    check("rst_ovf",  32'(bus.ovf),  32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add and latency
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, nb, sd, oa);
    check("add1_done",  32'(sd),       32'h1);
    check("add1_busy",  32'(nb),       32'd4);
    check("add1_sum",   32'(bus.sum),  32'h5555);
    check("add1_cout",  32'(bus.cout), 32'h0);
    check("add1_ovf",   32'(bus.ovf),  32'h0);
    tick();
    check("done_pulse", 32'(bus.done), 32'h0);
    check("sum_hold",   32'(bus.sum),  32'h5555);

    // Carry out of the top nibble
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, nb, sd, oa);
    check("wrap_sum",  32'(bus.sum),  32'h0000);
    check("wrap_cout", 32'(bus.cout), 32'h1);
    check("wrap_ovf",  32'(bus.ovf),  32'h0);

    // Signed overflow
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, nb, sd, oa);
    check("ovf_sum",  32'(bus.sum),  32'h8000);
    check("ovf_cout", 32'(bus.cout), 32'h0);
    check("ovf_ovf",  32'(bus.ovf),  32'h1);

    // Carry-in, and cout/ovf cleared at the accepting edge
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, nb, sd, oa);
    check("acc_clr_ovf", 32'(oa),      32'h0);
    check("cin_sum",     32'(bus.sum), 32'h0100);

`ifdef NSAC_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, nb, sd, oa);
    check("sub1_sum",  32'(bus.sum),  32'hFFFE);
    check("sub1_cout", 32'(bus.cout), 32'h0);
    check("sub1_ovf",  32'(bus.ovf),  32'h0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, nb, sd, oa);
    check("sub2_sum",  32'(bus.sum),  32'h7FFF);
    check("sub2_cout", 32'(bus.cout), 32'h1);
    check("sub2_ovf",  32'(bus.ovf),  32'h1);
`else
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, nb, sd, oa);
    check("sub_ignored", 32'(bus.sum), 32'h000C);
`endif

    // Back-to-back with start held high; operands change while busy
    bus.sub = 1'b0;
    bus.cin = 1'b0;
    bus.a = 16'h0010;
    bus.b = 16'h0020;
    bus.start = 1'b1;
    tick();
    bus.a = 16'h0001;
    bus.b = 16'h0001;
    ndone = 0;
    sd = 1'b0;
    for (int i = 0; i < 20 && !sd; i++) begin
      if (bus.done) sd = 1'b1;
      else tick();
    end
    if (sd) ndone++;
    check("b2b_first_sum", 32'(bus.sum), 32'h0030);
    tick();
    check("b2b_nogap_busy", 32'(bus.busy), 32'h1);
    bus.start = 1'b0;
    nb = 0;
    sd = 1'b0;
    for (int i = 0; i < 20 && !sd; i++) begin
      if (bus.busy) nb++;
      if (bus.done) sd = 1'b1;
      else tick();
    end
    if (sd) ndone++;
    check("b2b_done_cnt", 32'(ndone),   32'd2);
    check("b2b_busy2",    32'(nb),      32'd4);
    check("b2b_sum",      32'(bus.sum), 32'h0002);

    // Abort on the second RUN cycle
    bus.a = 16'h1111;
    bus.b = 16'h1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_sum",  32'(bus.sum),  32'h0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) ndone++;
      tick();
    end
    check("abort_nodone", 32'(ndone), 32'd0);

    // start together with abort in IDLE: nothing happens
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, nb, sd, oa);
    check("pre_sa_sum", 32'(bus.sum), 32'h0007);
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    check("sa_busy", 32'(bus.busy), 32'h0);
    tick();
    check("sa_busy2", 32'(bus.busy), 32'h0);
    check("sa_sum",   32'(bus.sum),  32'h0007);
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Asynchronous reset in the middle of RUN (idx=2)
    bus.a = 16'h2222;
    bus.b = 16'h1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("pre_rst_sum", 32'(bus.sum), 32'h0033);
    rst_n = 1'b0;
    #1;
    check("arst_sum",  32'(bus.sum),  32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    check("arst_cout", 32'(bus.cout), 32'h0);
    check("arst_ovf",  32'(bus.ovf),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, nb, sd, oa);
    check("post_rst_done", 32'(sd),      32'h1);
    check("post_rst_busy", 32'(nb),      32'd4);
    check("post_rst_sum",  32'(bus.sum), 32'h5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: NIBBLES, 4, operand width in 4-bit nibbles; W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a W-bit add; accepted only when busy=0.
REQ-005 abort  input  1  cancel an operation in progress.
REQ-006 a  input  W  operand A, sampled on the accepting edge.
REQ-007 b  input  W  operand B, sampled on the accepting edge.
REQ-008 cin  input  1  carry-in to nibble 0, sampled on the accepting edge.
REQ-009 sub  input  1  subtract request, sampled on the accepting edge (see REQ-027).
REQ-010 sum  output  W  result register.
REQ-011 cout  output  1  carry out of the top nibble.
REQ-012 ovf  output  1  signed two's-complement overflow of the W-bit result.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states IDLE, RUN, DONE; a single 4-bit ripple adder slice is reused once per RUN cycle.
REQ-016 IDLE or DONE, start=1, abort=0: latch a, b, cin; clear the nibble index to 0; go to RUN.
REQ-017 RUN: each edge computes nibble[idx] of a+b+carry; writes it to sum[4*idx+3:4*idx]; stores the slice carry into the carry register; increments idx.
REQ-018 Nibble 0 uses the latched cin; nibble i>0 uses the carry from nibble i-1.
REQ-019 After the RUN edge with idx=NIBBLES-1: cout = slice carry, ovf = carry-in XOR carry-out of bit W-1, next state DONE.
REQ-020 Latency: start accepted on edge k; done=1 in the cycle after edge k+NIBBLES; busy=1 for exactly NIBBLES cycles.
REQ-021 DONE lasts one cycle; it returns to IDLE unless REQ-016 applies, so back-to-back operations have no idle gap.
REQ-022 start while busy=1 is ignored; operands are not re-sampled.
REQ-023 abort=1 in RUN: next state IDLE; sum, cout and ovf are cleared to 0; done is not pulsed.
REQ-024 abort=1 together with start in IDLE or DONE: abort wins; state becomes or stays IDLE; outputs are unchanged.
REQ-025 sum, cout and ovf hold their values from the last completed operation until the next accepting edge, which clears cout and ovf.

Reset
REQ-026 rst_n=0, even mid-RUN, immediately forces IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, busy=0, done=0.

Configuration
REQ-027 Macro NSAC_SUB_EN defined: sub=1 latches ~b and forces carry-in 1, giving a-b; cout=1 means no borrow; ovf is signed subtraction overflow.
REQ-028 NSAC_SUB_EN undefined: the sub port exists but is ignored; the operation is always a+b+cin.

Structure
REQ-029 Shared package nsac_pkg holds the state enum (IDLE/RUN/DONE), NIBBLE_W=4 and the NIBBLES legal-range constants.
REQ-030 The datapath slice is the sub-module nsac_slice4: 4-bit ripple adder with inputs a, b, ci and outputs s, co; it is combinational, and the FSM registers its output.

Verification
REQ-031 NIBBLES=4: a=0x1234, b=0x4321, cin=0 -> after 4 busy cycles, done with sum=0x5555, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 NSAC_SUB_EN defined: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-034 start held high across DONE with new operands 0x0001+0x0001 -> second RUN begins with no IDLE cycle; done pulses twice; final sum=0x0002.
REQ-035 abort on the 2nd RUN cycle -> IDLE next cycle, no done, sum=0; start plus abort in IDLE -> stays IDLE.
REQ-036 rst_n low during RUN idx=2 -> all outputs 0 without waiting for a clock edge; first start after release completes normally in 4 cycles.
